// File: rtl/bridge_ctrl.sv
// bridge_ctrl: byte-stream sequencer for a BLOCK_BYTES-byte shift assembly register.
// Accepts bytes on a valid/ready handshake and shifts them into the register.
// A short final block is zero-padded. Each full block is held until the consumer acknowledges it.
module bridge_ctrl #(
  parameter int BLOCK_BYTES = 64,
  parameter int CNT_W       = 7,
  parameter int BLK_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  input  logic                 byte_last,
  output logic                 byte_ready,
  output logic                 shift_en,
  output logic [7:0]           shift_data,
  output logic                 blk_valid,
  output logic                 blk_last,
  input  logic                 blk_ack,
  output logic [CNT_W-1:0]     byte_cnt,
  output logic [BLK_CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [BLK_CNT_W-1:0]   blk_count_q, blk_count_d;
  logic                   blk_last_q, blk_last_d;

  // State and counter registers; a reset anywhere discards the partial block.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL;
      byte_cnt_q  <= '0;
      blk_count_q <= '0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      blk_count_q <= blk_count_d;
      blk_last_q  <= blk_last_d;
    end
  end

  // Next-state logic; in FILL, byte_ready is always 1, so byte_valid alone is the accept.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    blk_count_d = blk_count_q;
    blk_last_d  = blk_last_q;
    case (state_q)
      FILL: begin
        if (byte_valid) begin
          if (byte_cnt_q == LAST_CNT) begin
            state_d    = FULL;
            byte_cnt_d = '0;
            blk_last_d = byte_last;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_last) begin
              state_d    = PAD;
              blk_last_d = 1'b1;
            end
          end
        end
      end
      PAD: begin
        if (byte_cnt_q == LAST_CNT) begin
          state_d    = FULL;
          byte_cnt_d = '0;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      FULL: begin
        if (blk_ack) begin
          state_d     = FILL;
          blk_last_d  = 1'b0;
          blk_count_d = blk_count_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake and shift outputs; gated by n_rst so that nothing is asserted while in reset.
  always_comb begin
    byte_ready = 1'b0;
    shift_en   = 1'b0;
    shift_data = 8'h00;
    blk_valid  = 1'b0;
    case (state_q)
      FILL: begin
        byte_ready = n_rst;
        shift_en   = n_rst & byte_valid;
        shift_data = shift_en ? byte_in : 8'h00;
      end
      PAD: begin
        shift_en   = n_rst;
      end
      FULL: begin
        blk_valid  = n_rst;
      end
      default: ;
    endcase
  end

  assign blk_last  = blk_last_q;
  assign byte_cnt  = byte_cnt_q;
  assign blk_count = blk_count_q;

endmodule
